// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between the data cache and the AXI master DCache port.
// Writes are accepted in one cycle and drained in order; reads wait until the buffer is empty.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int BLK_W = 256
) (
    input  logic             aclk,
    input  logic             areset,
    // data cache side
    output logic             s_wrdy,
    input  logic [3:0]       s_wen,
    input  logic [31:0]      s_waddr,
    input  logic [31:0]      s_wdata,
    output logic             s_rrdy,
    input  logic [3:0]       s_ren,
    input  logic [31:0]      s_raddr,
    output logic             s_rvalid,
    output logic [BLK_W-1:0] s_rdata,
    // AXI master side
    input  logic             m_wrdy,
    output logic [3:0]       m_wen,
    output logic [31:0]      m_waddr,
    output logic [31:0]      m_wdata,
    input  logic             m_rrdy,
    output logic             m_ren,
    output logic [31:0]      m_raddr,
    input  logic             m_rvalid,
    input  logic [BLK_W-1:0] m_rdata,
    output logic             wb_empty
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WAIT} state_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [PW:0]     count;
    state_t          state, state_nxt;
    logic [3:0]      wen_q;
    logic            push, pop, launch;

    assign s_wrdy = (count != (PW+1)'(DEPTH));
    assign push   = (|s_wen) && s_wrdy;
    assign launch = (state == IDLE) && (count != '0) && m_wrdy;
    assign pop    = (state == WAIT) && m_wrdy;

    // Storage needs no reset: an entry is only read once count says it is valid.
    always_ff @(posedge aclk) begin
        if (push)
            mem[wptr] <= '{wen: s_wen, addr: s_waddr, data: s_wdata};
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry is latched at launch and held through WAIT, since the master
    // may sample address/data at any point before it re-raises wrdy.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wen_q   <= '0;
            m_waddr <= '0;
            m_wdata <= '0;
        end else if (launch) begin
            wen_q   <= mem[rptr].wen;
            m_waddr <= mem[rptr].addr;
            m_wdata <= mem[rptr].data;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    state_nxt = WAIT;   // master is still lowering wrdy here
            WAIT:    if (m_wrdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign m_wen    = (state == ISSUE) ? wen_q : 4'b0000;
    assign wb_empty = (count == '0) && (state == IDLE);

    assign s_rrdy   = m_rrdy && wb_empty;
    assign m_ren    = (|s_ren) && s_rrdy;
    assign m_raddr  = s_raddr;
    assign s_rvalid = m_rvalid;
    assign s_rdata  = m_rdata;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: directed table, hand sequences for ordering/wrap/read
// gating/reset, and random traffic against a queue-based reference model.
module tb_dcache_write_buffer;

    localparam int DEPTH = 4;
    localparam int BLK_W = 256;

    logic             aclk, areset;
    logic             s_wrdy, s_rrdy, s_rvalid, m_ren, wb_empty;
    logic [3:0]       s_wen, s_ren, m_wen;
    logic [31:0]      s_waddr, s_wdata, s_raddr, m_waddr, m_wdata, m_raddr;
    logic [BLK_W-1:0] s_rdata, m_rdata;
    logic             m_wrdy, m_rrdy, m_rvalid;

    dcache_write_buffer #(.DEPTH(DEPTH), .BLK_W(BLK_W)) dut (
        .aclk(aclk), .areset(areset),
        .s_wrdy(s_wrdy), .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .s_rrdy(s_rrdy), .s_ren(s_ren), .s_raddr(s_raddr),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .m_wrdy(m_wrdy), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_rrdy(m_rrdy), .m_ren(m_ren), .m_raddr(m_raddr),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .wb_empty(wb_empty)
    );

    initial aclk = 0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int fails  = 0;

    // Reference model: a queue of posted writes plus the drain progress of the head
    // (0 none, 1 presented to master, 2 master busy, 3 awaiting completion).
    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    int          ph;
    logic [31:0] l_addr, l_data;

    logic [31:0] seen[$];
    logic        got_ren, ren_empty;
    logic [31:0] ren_addr;

    task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ph = 0;
        l_addr = '0;
        l_data = '0;
    endtask

    task automatic set_idle();
        s_wen = '0; s_waddr = '0; s_wdata = '0;
        s_ren = '0; s_raddr = '0;
    endtask

    // Inputs are already applied (at the negedge). Compare, then advance one clock.
    task automatic cycle();
        logic       e_empty, e_rrdy, do_push, do_pop;
        logic [3:0] e_wen;
        #1;
        e_empty = (q.size() == 0) && (ph == 0);
        e_rrdy  = m_rrdy && e_empty;
        e_wen   = (ph == 1) ? q[0].wen : 4'h0;
        check("s_wrdy",   s_wrdy,   q.size() != DEPTH);
        check("wb_empty", wb_empty, e_empty);
        check("m_wen",    m_wen,    e_wen);
        check("m_waddr",  m_waddr,  l_addr);
        check("m_wdata",  m_wdata,  l_data);
        check("s_rrdy",   s_rrdy,   e_rrdy);
        check("m_ren",    m_ren,    (|s_ren) && e_rrdy);
        check("m_raddr",  m_raddr,  s_raddr);
        check("s_rvalid", s_rvalid, m_rvalid);
        check("s_rdata",  s_rdata,  m_rdata);
        if (m_wen != 0) seen.push_back(m_waddr);
        if (m_ren && !got_ren) begin
            got_ren = 1; ren_empty = wb_empty; ren_addr = m_raddr;
        end
        @(posedge aclk);
        do_push = (|s_wen) && (q.size() != DEPTH);
        do_pop  = 0;
        case (ph)
            0: if (q.size() != 0 && m_wrdy) begin
                   ph = 1; l_addr = q[0].addr; l_data = q[0].data;
               end
            1: ph = 2;
            2: ph = 3;
            default: if (m_wrdy) begin ph = 0; do_pop = 1; end
        endcase
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{wen: s_wen, addr: s_waddr, data: s_wdata});
        @(negedge aclk);
    endtask

    // Data cache protocol: no write while full, never write and read together.
    always @(posedge aclk) begin
        if (!areset && (|s_wen) && !s_wrdy) begin
            fails++; $display("FAIL proto_write_while_full");
        end
        if (!areset && (|s_wen) && (|s_ren)) begin
            fails++; $display("FAIL proto_write_and_read");
        end
    end

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr, data;
        logic        mw;
        logic [3:0]  ren;
        logic [31:0] raddr;
        logic        e_wrdy;
        logic [3:0]  e_wen;
        logic        e_empty, e_ren;
        logic [31:0] e_waddr, e_wdata;
    } vec_t;
    vec_t tbl[14];

    initial begin
        // single write with a 2-cycle wrdy dip, then a byte-enable write, then a read
        tbl[0]  = '{4'hF, 32'h1C00_0010, 32'hDEAD_BEEF, 1, 0, 0, 1, 4'h0, 1, 0, 32'h0, 32'h0};
        tbl[1]  = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 0, 0, 32'h0, 32'h0};
        tbl[2]  = '{4'h0, 0, 0, 1, 0, 0, 1, 4'hF, 0, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[3]  = '{4'h0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[4]  = '{4'h0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[5]  = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 0, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[6]  = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 1, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[7]  = '{4'h3, 32'h100, 32'h1234_5678, 1, 0, 0, 1, 4'h0, 1, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[8]  = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 0, 0, 32'h1C00_0010, 32'hDEAD_BEEF};
        tbl[9]  = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h3, 0, 0, 32'h100, 32'h1234_5678};
        tbl[10] = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 0, 0, 32'h100, 32'h1234_5678};
        tbl[11] = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 0, 0, 32'h100, 32'h1234_5678};
        tbl[12] = '{4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 1, 0, 32'h100, 32'h1234_5678};
        tbl[13] = '{4'h0, 0, 0, 1, 4'hF, 32'h40, 1, 4'h0, 1, 1, 32'h100, 32'h1234_5678};

        areset = 1; set_idle();
        m_wrdy = 1; m_rrdy = 1; m_rvalid = 0; m_rdata = '0;
        got_ren = 0; ren_empty = 0; ren_addr = '0;
        model_reset();
        repeat (2) @(negedge aclk);
        #1;
        check("rst_s_wrdy", s_wrdy, 1'b1);
        check("rst_wb_empty", wb_empty, 1'b1);
        check("rst_m_wen", m_wen, 4'h0);
        check("rst_m_waddr", m_waddr, 32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        check("rst_s_rrdy", s_rrdy, 1'b1);
        @(negedge aclk);
        areset = 0;

        // directed table
        for (int i = 0; i < 14; i++) begin
            s_wen = tbl[i].wen; s_waddr = tbl[i].addr; s_wdata = tbl[i].data;
            m_wrdy = tbl[i].mw; s_ren = tbl[i].ren; s_raddr = tbl[i].raddr;
            #1;
            check($sformatf("tbl%0d_s_wrdy", i), s_wrdy, tbl[i].e_wrdy);
            check($sformatf("tbl%0d_m_wen", i), m_wen, tbl[i].e_wen);
            check($sformatf("tbl%0d_wb_empty", i), wb_empty, tbl[i].e_empty);
            check($sformatf("tbl%0d_m_ren", i), m_ren, tbl[i].e_ren);
            check($sformatf("tbl%0d_m_waddr", i), m_waddr, tbl[i].e_waddr);
            check($sformatf("tbl%0d_m_wdata", i), m_wdata, tbl[i].e_wdata);
            cycle();
        end
        set_idle();

        // four back-to-back writes with the master stalled, then drain in order
        m_wrdy = 0;
        for (int k = 0; k < 4; k++) begin
            s_wen = 4'hF; s_waddr = 32'(4 * k); s_wdata = 32'(k + 1);
            cycle();
        end
        set_idle();
        #1 check("full_s_wrdy", s_wrdy, 1'b0);
        seen.delete();
        m_wrdy = 1;
        for (int i = 0; i < 40 && !(seen.size() == 4 && q.size() == 0 && ph == 0); i++) cycle();
        check("fill_drain_count", seen.size(), 4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            check($sformatf("fill_order%0d", k), seen[k], 32'(4 * k));

        // push landing in the pop cycle at count=3; eight writes wrap the pointers
        begin
            int pushed;
            seen.delete();
            m_wrdy = 0;
            for (pushed = 0; pushed < 3; pushed++) begin
                s_wen = 4'hF; s_waddr = 32'h200 + 32'(4 * pushed); s_wdata = 32'(pushed);
                cycle();
            end
            set_idle();
            m_wrdy = 1;
            for (int i = 0; i < 200 && !(pushed == 8 && q.size() == 0 && ph == 0); i++) begin
                set_idle();
                if (ph == 3 && pushed < 8) begin
                    s_wen = 4'hF; s_waddr = 32'h200 + 32'(4 * pushed); s_wdata = 32'(pushed);
                    pushed++;
                end
                cycle();
            end
            set_idle();
            check("wrap_count", seen.size(), 8);
            for (int k = 0; k < 8 && k < seen.size(); k++)
                check($sformatf("wrap_order%0d", k), seen[k], 32'h200 + 32'(4 * k));
        end

        // read held off behind two pending writes
        m_wrdy = 0;
        for (int k = 0; k < 2; k++) begin
            s_wen = 4'hF; s_waddr = 32'h300 + 32'(4 * k); s_wdata = 32'h0; cycle();
        end
        set_idle();
        m_wrdy = 1; m_rrdy = 1; s_ren = 4'hF; s_raddr = 32'h40;
        m_rvalid = 1; m_rdata = {8{32'hA5A5_0F0F}};
        got_ren = 0;
        for (int i = 0; i < 60 && !got_ren; i++) cycle();
        check("rd_gate_seen", got_ren, 1'b1);
        check("rd_gate_empty", ren_empty, 1'b1);
        check("rd_gate_addr", ren_addr, 32'h40);
        set_idle(); m_rvalid = 0; m_rdata = '0;

        // reset while BUSY with two entries buffered
        m_wrdy = 0;
        for (int k = 0; k < 2; k++) begin
            s_wen = 4'hF; s_waddr = 32'h400 + 32'(4 * k); s_wdata = 32'h0; cycle();
        end
        set_idle();
        m_wrdy = 1;
        for (int i = 0; i < 20 && ph != 2; i++) cycle();
        check("rst_mid_reached_busy", ph, 2);
        areset = 1;
        #1;
        check("rst_mid_m_wen", m_wen, 4'h0);
        check("rst_mid_wb_empty", wb_empty, 1'b1);
        check("rst_mid_s_wrdy", s_wrdy, 1'b1);
        model_reset();
        @(negedge aclk);
        areset = 0;
        seen.delete();
        repeat (10) cycle();
        check("rst_mid_no_wen", seen.size(), 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            s_wen   = (q.size() < DEPTH && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            s_waddr = $urandom; s_wdata = $urandom;
            s_ren   = (s_wen == 0 && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            s_raddr = $urandom;
            m_wrdy  = ($urandom_range(0, 9) < 7);
            m_rrdy  = ($urandom_range(0, 9) < 8);
            m_rvalid = 1'($urandom);
            m_rdata = {8{32'($urandom)}};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
